vga_sprite_engine: RTL

//  Parametrised VGA timing generator with one hardware sprite overlay. Successor to the fixed 640x480 controller/display pair.

---
 rtl/vga_sprite_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_sprite_engine                                         |
// | Function : parametrised VGA timing generator with one ROM sprite     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module vga_sprite_engine #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int          SPR_W     = 100,
    parameter int          SPR_H     = 100,
    parameter int          AW        = 14,
    parameter int          RD_LAT    = 1,
    parameter logic [15:0] KEY_COLOR = 16'hF81F,
    parameter logic [11:0] BG_COLOR  = 12'hFCD,
    parameter int          X0        = 270,
    parameter int          Y0        = 380
) (
    input  logic          clk_vga,
    input  logic          rst,
    input  logic          pos_wr,
    input  logic [11:0]   pos_x,
    input  logic [11:0]   pos_y,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    output logic          frame_tick
);

    localparam int         C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int         C_PD      = RD_LAT + 1;
    localparam logic [3:0] C_CTL_RST = {~SYNC_POL, ~SYNC_POL, 2'b00};

    logic [11:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0]          pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [11:0]          live_x_q, live_x_d, live_y_q, live_y_d;
    logic [AW-1:0]        row_base_q, row_base_d, rom_addr_q, rom_addr_d;
    logic [C_PD-1:0][3:0] ctl_q, ctl_d;
    logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [11:0]          rgb_q, rgb_d;

    logic [12:0] w_h, w_v, w_px, w_py;
    logic        w_eol, w_eof, w_active, w_col_in, w_row_in, w_inside;
    logic        w_hs_act, w_vs_act;
    logic [3:0]  w_ctl0, w_tap;

    always_comb begin
        w_h      = {1'b0, h_cnt_q};
        w_v      = {1'b0, v_cnt_q};
        w_px     = {1'b0, live_x_q};
        w_py     = {1'b0, live_y_q};
        w_eol    = (h_cnt_q == 12'(C_H_TOTAL - 1));
        w_eof    = w_eol && (v_cnt_q == 12'(C_V_TOTAL - 1));
        w_active = (w_h < 13'(H_ACTIVE)) && (w_v < 13'(V_ACTIVE));
        // 13-bit compares keep px+SPR_W from wrapping for positions near 4095
        w_col_in = (w_h >= w_px) && (w_h < w_px + 13'(SPR_W));
        w_row_in = (w_v >= w_py) && (w_v < w_py + 13'(SPR_H));
        w_inside = w_active && w_col_in && w_row_in;
        w_hs_act = (w_h >= 13'(H_ACTIVE + H_FP)) && (w_h < 13'(H_ACTIVE + H_FP + H_SYNC));
        w_vs_act = (w_v >= 13'(V_ACTIVE + V_FP)) && (w_v < 13'(V_ACTIVE + V_FP + V_SYNC));
        w_ctl0   = {w_hs_act ? SYNC_POL : ~SYNC_POL,
                    w_vs_act ? SYNC_POL : ~SYNC_POL,
                    w_active, w_inside};
        w_tap    = ctl_q[C_PD-1];
    end

    always_comb begin
        h_cnt_d    = h_cnt_q + 12'd1;
        v_cnt_d    = v_cnt_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        live_x_d   = live_x_q;
        live_y_d   = live_y_q;
        row_base_d = row_base_q;
        if (w_eol) begin
            h_cnt_d = 12'd0;
            v_cnt_d = w_eof ? 12'd0 : v_cnt_q + 12'd1;
        end
        if (pos_wr) begin
            pend_x_d = pos_x;
            pend_y_d = pos_y;
        end
        // Live position only moves at the last cycle of the frame; a write on
        // that very cycle is forwarded so it is not delayed a whole frame.
        if (w_eof) begin
            live_x_d   = pend_x_d;
            live_y_d   = pend_y_d;
            row_base_d = '0;
        end else if (w_eol && w_row_in) begin
            row_base_d = row_base_q + AW'(SPR_W);
        end
        rom_addr_d = w_inside ? row_base_q + AW'(w_h - w_px) : rom_addr_q;
    end

    always_comb begin
        ctl_d        = {ctl_q[C_PD-2:0], w_ctl0};
        hsync_d      = w_tap[3];
        vsync_d      = w_tap[2];
        de_d         = w_tap[1];
        frame_tick_d = w_eof;
        rgb_d        = BG_COLOR;
        // The tap stage lines up with rom_data for the same pixel.
        if (!w_tap[1]) begin
            rgb_d = 12'h000;
        end else if (w_tap[0] && (rom_data != KEY_COLOR)) begin
            rgb_d = {rom_data[15:12], rom_data[10:7], rom_data[4:1]};
        end
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pend_x_q     <= 12'(X0);
            pend_y_q     <= 12'(Y0);
            live_x_q     <= 12'(X0);
            live_y_q     <= 12'(Y0);
            row_base_q   <= '0;
            rom_addr_q   <= '0;
            ctl_q        <= {C_PD{C_CTL_RST}};
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            de_q         <= 1'b0;
            rgb_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            live_x_q     <= live_x_d;
            live_y_q     <= live_y_d;
            row_base_q   <= row_base_d;
            rom_addr_q   <= rom_addr_d;
            ctl_q        <= ctl_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign de         = de_q;
    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
